poly_horner_eval: RTL



---
 rtl/poly_horner_eval.sv | 134 +++++++++++++
 1 files changed

// File: rtl/poly_horner_eval.sv
// rtl/poly_horner_eval.sv - Horner-rule polynomial evaluator with one shared multiply/add unit.
// Holds the coefficient file, x and the accumulator, and sequences MUL/ADD steps from an FSM.
module poly_horner_eval #(
  parameter int WIDTH  = 16,
  parameter int DEGREE = 2,
  parameter int SIGNED = 0,
  parameter int AW     = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  input  logic [WIDTH-1:0] x,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] TOP_ADDR  = AW'(DEGREE);
  localparam logic [AW-1:0] START_IDX = (DEGREE > 0) ? AW'(DEGREE - 1) : '0;
  localparam logic [AW:0]   MAX_ADDR  = (AW + 1)'(DEGREE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] coef [DEPTH];
  // Snapshot taken at start so a same-cycle coefficient write cannot leak into the run.
  logic [WIDTH-1:0] work [DEPTH];
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] xr;
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] result_r;
  logic             ovf_r;

  logic [2*WIDTH-1:0] acc_ext, xr_ext, prod;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic               mul_ovf, add_ovf;
  logic               addr_ok;

  assign addr_ok = ({1'b0, coef_addr} <= MAX_ADDR);

  // Extending both operands to 2*WIDTH makes one unsigned multiply serve both signednesses.
  assign acc_ext = (SIGNED != 0) ? {{WIDTH{acc[WIDTH-1]}}, acc} : {{WIDTH{1'b0}}, acc};
  assign xr_ext  = (SIGNED != 0) ? {{WIDTH{xr[WIDTH-1]}}, xr} : {{WIDTH{1'b0}}, xr};
  assign prod    = acc_ext * xr_ext;
  assign mul_ovf = (SIGNED != 0) ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                 : (|prod[2*WIDTH-1:WIDTH]);

  assign addend  = work[idx];
  assign sum     = {1'b0, acc} + {1'b0, addend};
  assign add_ovf = (SIGNED != 0) ? ((acc[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]))
                                 : sum[WIDTH];

  always_ff @(posedge clk) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (DEGREE == 0) ? S_DONE : S_MUL;
      end
      S_MUL:  state_nx = S_ADD;
      S_ADD:  state_nx = (idx == '0) ? S_DONE : S_MUL;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      acc      <= '0;
      xr       <= '0;
      idx      <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        coef[i] <= '0;
        work[i] <= '0;
      end
    end else begin
      if (state == S_IDLE && coef_we && addr_ok) coef[coef_addr] <= coef_data;
      case (state)
        S_IDLE: begin
          if (start) begin
            xr    <= x;
            acc   <= coef[TOP_ADDR];
            idx   <= START_IDX;
            ovf_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) work[i] <= coef[i];
            if (DEGREE == 0) result_r <= coef[0];
          end
        end
        S_MUL: begin
          acc <= prod[WIDTH-1:0];
          if (mul_ovf) ovf_r <= 1'b1;
        end
        S_ADD: begin
          acc <= sum[WIDTH-1:0];
          if (add_ovf) ovf_r <= 1'b1;
          if (idx == '0) result_r <= sum[WIDTH-1:0];
          else           idx      <= idx - AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result   = result_r;
  assign overflow = ovf_r;

endmodule
